// File: rtl/alu_arbiter.sv
// Round-robin sharing of one registered ALU among NREQ requesters.
// Optional ALU_ARB_PERF_EN adds saturating op and busy-cycle counters.
module alu_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*4-1:0] req_op,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_data,
    output logic [3:0]        alu_ctrl,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    input  logic [W-1:0]      alu_y,
    output logic              busy
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]       perf_ops,
    output logic [31:0]       perf_busy
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] id_reg;
    logic [IDW-1:0] gnt_idx;
    logic           gnt_any;
    logic [3:0]     sel_op;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    int             cand;

    // Search downward so the nearest requester after rr_ptr wins last.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = (int'(rr_ptr) + k) % NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (cand == i && req_valid[i]) begin
                    gnt_any = 1'b1;
                    gnt_idx = IDW'(i);
                end
            end
        end
    end

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_op = req_op[4*i +: 4];
                sel_a  = req_a[W*i +: W];
                sel_b  = req_b[W*i +: W];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!reset && state == IDLE && gnt_any) begin
            for (int i = 0; i < NREQ; i++) begin
                req_ready[i] = (gnt_idx == IDW'(i));
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (gnt_any) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= IDW'(NREQ - 1);
            id_reg   <= '0;
            alu_ctrl <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && gnt_any) begin
                alu_ctrl <= sel_op;
                alu_a    <= sel_a;
                alu_b    <= sel_b;
                id_reg   <= gnt_idx;
                rr_ptr   <= gnt_idx;
            end
            // ALU result is valid during WAIT, one cycle after ISSUE.
            if (state == WAIT) begin
                rsp_data <= alu_y;
                rsp_id   <= id_reg;
            end
        end
    end

`ifdef ALU_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_ops  <= '0;
            perf_busy <= '0;
        end else begin
            if (rsp_valid && rsp_ready && perf_ops != '1)
                perf_ops <= perf_ops + 32'd1;
            if (busy && perf_busy != '1)
                perf_busy <= perf_busy + 32'd1;
        end
    end
`endif

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single registered 16-bit ALU between NREQ requesters, e.g. the decode/execute path, an address generator and a debug port. Round-robin arbitration selects one request at a time. The block latches the op and operands, sequences the ALU's one-cycle registered latency, and returns the result with the requester ID on one response channel with backpressure. One operation is in flight at a time.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 16, operand/result width; must match the ALU datapath
IDW, 2, requester ID width, $clog2(NREQ) (min 1)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous active-high reset
req_valid  in  NREQ  request valid, one bit per requester
req_ready  out  NREQ  request accepted (one-hot or zero)
req_op  in  NREQ*4  per-requester ALU op code, requester i at [4i+3:4i]
req_a  in  NREQ*W  per-requester operand a, requester i at [W*i+W-1:W*i]
req_b  in  NREQ*W  per-requester operand b, same packing
rsp_valid  out  1  result valid
rsp_ready  in  1  response consumer ready
rsp_id  out  IDW  index of the requester that owns rsp_data
rsp_data  out  W  ALU result
alu_ctrl  out  4  to ALU ctrl
alu_a  out  W  to ALU a
alu_b  out  W  to ALU b
alu_y  in  W  from ALU y (registered in the ALU, valid 1 cycle after ctrl/a/b sampled)
busy  out  1  high whenever state != IDLE

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset, sampled only at the rising edge of clk.
- Reset values: state IDLE, rr_ptr=NREQ-1, alu_ctrl=0, alu_a=0, alu_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0. req_ready is forced to 0 in any cycle where reset=1.
- FSM states:
  - IDLE -> ISSUE when any req_valid is set.
  - ISSUE -> WAIT, unconditionally.
  - WAIT -> RESP, unconditionally.
  - RESP -> IDLE when rsp_ready=1; otherwise stay in RESP.
- Arbitration (IDLE only):
  - grant g = first i with req_valid[i]=1, searching from rr_ptr+1 upward, mod NREQ.
  - req_ready[g]=1 combinationally in that same cycle; all other req_ready bits are 0.
  - req_ready is 0 in every state other than IDLE.
- Accept edge (IDLE, any valid):
  - alu_ctrl/alu_a/alu_b <= req_op/req_a/req_b of g.
  - id_reg <= g; rr_ptr <= g.
  - rr_ptr changes only at an accept edge.
- ISSUE: alu_* are stable registers; the ALU samples them at the end of this cycle.
- WAIT: rsp_data <= alu_y and rsp_id <= id_reg at the end of the cycle.
- RESP:
  - rsp_valid=1. rsp_data and rsp_id are held stable until the handshake (rsp_valid & rsp_ready).
  - rsp_valid is deasserted in the cycle after the handshake.
- Latency: rsp_valid is first high 3 cycles after the accept edge. Minimum issue interval is 4 cycles.
- alu_ctrl/alu_a/alu_b hold their last values in IDLE and RESP. The ALU's output in those cycles is ignored.
- Requester contract: hold valid and payload stable until ready. The block samples the payload only at the accept edge, so a payload change after acceptance has no effect.
- Arithmetic: result width W, with wrap/truncation exactly as the ALU produces it; the arbiter does not modify data.
- Reset mid-operation (any state): the in-flight op is dropped and no response is produced. rr_ptr returns to NREQ-1.
- A req_valid that rises during ISSUE/WAIT/RESP waits; it is arbitrated on the next IDLE cycle.

Optional Feature:
ALU_ARB_PERF_EN:
- Defined: adds outputs perf_ops (32) and perf_busy (32), both reset to 0.
  - perf_ops increments on each response handshake.
  - perf_busy increments on each cycle with busy=1.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- After reset, only req_valid[0]=1 with op=ALU_OP_ADD, a=5, b=3 -> req_ready=4'b0001 in that cycle; rsp_valid high 3 cycles after accept; rsp_id=0, rsp_data=8.
- All four requesters hold valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1, with one accept every 4 cycles.
- rr_ptr=1 after the previous grant, req_valid=4'b1010 -> grant 3; then with req_valid=4'b0010 -> grant 1.
- ALU_OP_SUB, a=16'h0000, b=1, rsp_ready held low 5 cycles -> rsp_data=16'hFFFF held stable, rsp_valid high and req_ready=0 throughout; one response only.
- Assert reset during WAIT of a requester-2 op -> no rsp_valid; rsp_valid=0 and busy=0 after the reset edge; with req_valid=4'b0101 the next accept grants 0.
- With ALU_ARB_PERF_EN defined: 3 back-to-back ops, each with a 1-cycle response stall -> perf_ops=3, perf_busy=12.
